// File: rtl/led_seq_pkg.sv
// ---------------------------------------------------------------------------
// led_seq_pkg
// Shared types and helpers for the RGB/multi-channel LED sequencer.
//   mode_e        : pattern mode (rotate, bounce, breathe, off)
//   duty_dir_e    : breathe duty triangle direction (UP/DOWN)
//   pat_dir_e     : bounce pattern direction (UP = towards channel N_CH-1)
//   led_polarity  : maps a logical "lit" to the physical pin level
// ---------------------------------------------------------------------------
package led_seq_pkg;

   typedef enum logic [1:0] {
      MODE_ROTATE  = 2'd0,
      MODE_BOUNCE  = 2'd1,
      MODE_BREATHE = 2'd2,
      MODE_OFF     = 2'd3
   } mode_e;

   typedef enum logic {
      DUTY_UP   = 1'b0,
      DUTY_DOWN = 1'b1
   } duty_dir_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } pat_dir_e;

   function automatic logic led_polarity(input logic lit, input logic active_low);
      return active_low ? ~lit : lit;
   endfunction

endpackage

// File: rtl/led_seq_pwm_gen.sv
// ---------------------------------------------------------------------------
// led_pwm_gen
// Free-running PWM counter plus duty compare, shared by all LED channels.
// Optional gamma stage selected by the LED_GAMMA_EN macro:
//   defined     : duty_eff = (duty*duty) >> PWM_BITS, registered (one extra
//                 cycle of lag between duty and the compare)
//   not defined : duty_eff = duty, no multiplier
// Ports:
//   CLK_IN    in  1         system clock
//   RST_N     in  1         synchronous active-low reset
//   i_duty    in  PWM_BITS  requested duty (0 = fully dark)
//   o_pwm_on  out 1         1 while pwm_cnt < duty_eff (combinational)
// ---------------------------------------------------------------------------
module led_pwm_gen #(
   parameter int PWM_BITS = 8
) (
   input  logic                CLK_IN,
   input  logic                RST_N,
   input  logic [PWM_BITS-1:0] i_duty,
   output logic                o_pwm_on
);

   logic [PWM_BITS-1:0] r_cnt;
   logic [PWM_BITS-1:0] w_duty_eff;

   always_ff @(posedge CLK_IN) begin
      if (!RST_N) r_cnt <= '0;
      else        r_cnt <= r_cnt + PWM_BITS'(1);
   end

`ifdef LED_GAMMA_EN
   logic [2*PWM_BITS-1:0] w_sq;
   logic [PWM_BITS-1:0]   r_duty_eff;

   assign w_sq = i_duty * i_duty;

   always_ff @(posedge CLK_IN) begin
      if (!RST_N) r_duty_eff <= '0;
      else        r_duty_eff <= PWM_BITS'(w_sq >> PWM_BITS);
   end

   assign w_duty_eff = r_duty_eff;
`else
   assign w_duty_eff = i_duty;
`endif

   assign o_pwm_on = (r_cnt < w_duty_eff);

endmodule

// File: rtl/rgb_led_sequencer.sv
// ---------------------------------------------------------------------------
// rgb_led_sequencer
// Multi-channel LED pattern sequencer: rotate, bounce, breathe (PWM-dimmed
// rotate) or off. Step timing from a prescaler; outputs registered.
// Build option: LED_GAMMA_EN (gamma-2 duty curve in led_pwm_gen).
// Ports:
//   CLK_IN      in  1     system clock
//   RST_N       in  1     synchronous active-low reset
//   MODE        in  2     0 rotate, 1 bounce, 2 breathe, 3 off
//   PAUSE       in  1     freeze prescaler/pattern/dir/duty (PWM keeps running)
//   LED         out N_CH  LED drive, polarity per ACTIVE_LOW
//   STEP_PULSE  out 1     1-cycle strobe each time the pattern advances
// ---------------------------------------------------------------------------
module rgb_led_sequencer
   import led_seq_pkg::*;
#(
   parameter int N_CH          = 3,
   parameter int STEP_TICKS    = 24_000_000,
   parameter int BREATHE_TICKS = 93_750,
   parameter int PWM_BITS      = 8,
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic            CLK_IN,
   input  logic            RST_N,
   input  logic [1:0]      MODE,
   input  logic            PAUSE,
   output logic [N_CH-1:0] LED,
   output logic            STEP_PULSE
);

   localparam int MAX_T = (STEP_TICKS > BREATHE_TICKS) ? STEP_TICKS : BREATHE_TICKS;
   localparam int PRE_W = $clog2(MAX_T);
   localparam logic [PRE_W-1:0]    STEP_LAST    = PRE_W'(STEP_TICKS - 1);
   localparam logic [PRE_W-1:0]    BREATHE_LAST = PRE_W'(BREATHE_TICKS - 1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX     = '1;

   mode_e               w_mode;
   mode_e               r_mode_prev;
   logic [PRE_W-1:0]    r_presc,    w_presc_nxt;
   logic [N_CH-1:0]     r_pattern,  w_pattern_nxt;
   pat_dir_e            r_dir,      w_dir_nxt;
   logic [PWM_BITS-1:0] r_duty,     w_duty_nxt;
   duty_dir_e           r_duty_st,  w_duty_st_nxt;
   logic [N_CH-1:0]     r_led,      w_led_nxt;
   logic                r_step_pulse;
   logic                w_step;
   logic [PRE_W-1:0]    w_last;
   logic [N_CH-1:0]     w_rot;
   logic [N_CH-1:0]     w_bounce;
   logic                w_go_up;
   logic                w_pwm_on;
   logic                w_lit_en;

   assign w_mode = mode_e'(MODE);

   led_pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
      .CLK_IN   (CLK_IN),
      .RST_N    (RST_N),
      .i_duty   (r_duty),
      .o_pwm_on (w_pwm_on)
   );

   // Rotate left with wrap; for N_CH=1 this reduces to the identity.
   assign w_rot = (r_pattern << 1) | (r_pattern >> (N_CH - 1));

   // Bounce reverses at either end: the tick that finds the pattern at an
   // end already moves the other way.
   assign w_go_up  = (r_dir == DIR_UP) ? ~r_pattern[N_CH-1] : r_pattern[0];
   assign w_bounce = (N_CH == 1) ? r_pattern
                   : (w_go_up ? (r_pattern << 1) : (r_pattern >> 1));

   // Next-state logic for prescaler, pattern/dir FSM and duty triangle FSM.
   always_comb begin
      w_presc_nxt   = r_presc;
      w_pattern_nxt = r_pattern;
      w_dir_nxt     = r_dir;
      w_duty_nxt    = r_duty;
      w_duty_st_nxt = r_duty_st;
      w_step        = 1'b0;
      w_last        = (w_mode == MODE_BREATHE) ? BREATHE_LAST : STEP_LAST;

      if (w_mode != r_mode_prev) begin
         w_presc_nxt   = '0;
         w_duty_nxt    = '0;
         w_duty_st_nxt = DUTY_UP;
         w_dir_nxt     = DIR_UP;
      end else if (w_mode == MODE_OFF) begin
         w_presc_nxt = '0;
      end else if (!PAUSE) begin
         if (r_presc != w_last) begin
            w_presc_nxt = r_presc + PRE_W'(1);
         end else begin
            w_presc_nxt = '0;
            case (w_mode)
               MODE_ROTATE: begin
                  w_pattern_nxt = w_rot;
                  w_step        = 1'b1;
               end
               MODE_BOUNCE: begin
                  w_pattern_nxt = w_bounce;
                  w_dir_nxt     = w_go_up ? DIR_UP : DIR_DOWN;
                  w_step        = 1'b1;
               end
               MODE_BREATHE: begin
                  if (r_duty_st == DUTY_UP) begin
                     if (r_duty == DUTY_MAX) begin
                        w_duty_nxt    = r_duty - PWM_BITS'(1);
                        w_duty_st_nxt = DUTY_DOWN;
                     end else begin
                        w_duty_nxt = r_duty + PWM_BITS'(1);
                     end
                  end else begin
                     w_duty_nxt = r_duty - PWM_BITS'(1);
                     // Bottom of the triangle: hand over to the next channel.
                     if (r_duty == PWM_BITS'(1)) begin
                        w_duty_st_nxt = DUTY_UP;
                        w_pattern_nxt = w_rot;
                        w_step        = 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end

      case (w_mode)
         MODE_ROTATE, MODE_BOUNCE: w_lit_en = 1'b1;
         MODE_BREATHE:             w_lit_en = w_pwm_on;
         default:                  w_lit_en = 1'b0;
      endcase

      for (int i = 0; i < N_CH; i++) begin
         w_led_nxt[i] = led_polarity(r_pattern[i] & w_lit_en, ACTIVE_LOW);
      end
   end

   always_ff @(posedge CLK_IN) begin
      if (!RST_N) begin
         r_mode_prev  <= w_mode;
         r_presc      <= '0;
         r_pattern    <= N_CH'(1);
         r_dir        <= DIR_UP;
         r_duty       <= '0;
         r_duty_st    <= DUTY_UP;
         r_led        <= {N_CH{ACTIVE_LOW}};
         r_step_pulse <= 1'b0;
      end else begin
         r_mode_prev  <= w_mode;
         r_presc      <= w_presc_nxt;
         r_pattern    <= w_pattern_nxt;
         r_dir        <= w_dir_nxt;
         r_duty       <= w_duty_nxt;
         r_duty_st    <= w_duty_st_nxt;
         r_led        <= w_led_nxt;
         r_step_pulse <= w_step;
      end
   end

   assign LED        = r_led;
   assign STEP_PULSE = r_step_pulse;

endmodule

// File: tb/tb_rgb_led_sequencer.sv
module tb_rgb_led_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] mode;
   logic       pause;
   logic [2:0] led;
   logic       step_pulse;

   int checks   = 0;
   int failures = 0;

   rgb_led_sequencer #(
      .N_CH(3), .STEP_TICKS(4), .BREATHE_TICKS(2), .PWM_BITS(3), .ACTIVE_LOW(1'b1)
   ) dut (
      .CLK_IN     (clk),
      .RST_N      (rst_n),
      .MODE       (mode),
      .PAUSE      (pause),
      .LED        (led),
      .STEP_PULSE (step_pulse)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input logic [1:0] m, input int cycles);
      rst_n = 1'b0;
      mode  = m;
      pause = 1'b0;
      tick_n(cycles);
   endtask

   initial begin
      logic [2:0] rot_exp [4];
      logic [2:0] bnc_exp [5];
      logic [2:0] onehot;
      logic [2:0] exp_led;
      int t, tm, d, t2, d2, eff, idx, lit_cnt;

      rot_exp = '{3'b110, 3'b101, 3'b011, 3'b110};
      bnc_exp = '{3'b110, 3'b101, 3'b011, 3'b101, 3'b110};

      // Reset state, then rotate 001->010->100->001
      do_reset(2'd0, 2);
      chk("reset_led", led, 3'b111);
      chk("reset_sp", step_pulse, 1'b0);
      rst_n = 1'b1;
      for (int c = 1; c <= 13; c++) begin
         tick_n(1);
         chk("rot_led", led, rot_exp[(c - 1) / 4]);
         chk("rot_sp", step_pulse, (c % 4) == 0);
      end

      // Bounce 001,010,100,010,001
      do_reset(2'd1, 2);
      rst_n = 1'b1;
      for (int c = 1; c <= 17; c++) begin
         tick_n(1);
         chk("bnc_led", led, bnc_exp[(c - 1) / 4]);
         chk("bnc_sp", step_pulse, (c % 4) == 0);
      end

      // Breathe: triangle duty, 2 clks per step, rotate at bottom of triangle
      do_reset(2'd2, 2);
      rst_n = 1'b1;
      for (int n = 1; n <= 60; n++) begin
         tick_n(1);
         t   = (n - 1) / 2;
         tm  = t % 14;
         d   = (tm <= 7) ? tm : 14 - tm;
         idx = (t / 14) % 3;
`ifdef LED_GAMMA_EN
         if (n == 1) eff = 0;
         else begin
            t2  = ((n - 2) / 2) % 14;
            d2  = (t2 <= 7) ? t2 : 14 - t2;
            eff = (d2 * d2) >> 3;
         end
`else
         t2  = 0;
         d2  = 0;
         eff = d;
`endif
         onehot  = 3'b001 << idx;
         exp_led = (((n - 1) % 8) < eff) ? ~onehot : 3'b111;
         chk("brth_led", led, exp_led);
         chk("brth_sp", step_pulse, ((n % 2) == 0) && (((n / 2) % 14) == 0));
      end

      // PWM window at frozen duty 4: 4 of 8 lit (2 of 8 with gamma)
      do_reset(2'd2, 2);
      rst_n = 1'b1;
      tick_n(8);
      pause = 1'b1;
      tick_n(2);
      lit_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         tick_n(1);
         if (led[0] == 1'b0) lit_cnt++;
         chk("win_other_ch", led[2:1], 2'b11);
         chk("win_sp", step_pulse, 1'b0);
      end
`ifdef LED_GAMMA_EN
      chk("pwm_window", lit_cnt, 2);
`else
      chk("pwm_window", lit_cnt, 4);
`endif

      // PAUSE for 10 cycles mid-step in rotate
      do_reset(2'd0, 2);
      rst_n = 1'b1;
      tick_n(2);
      pause = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick_n(1);
         chk("pause_sp", step_pulse, 1'b0);
         chk("pause_led", led, 3'b110);
      end
      pause = 1'b0;
      tick_n(1);
      chk("resume_sp0", step_pulse, 1'b0);
      tick_n(1);
      chk("resume_sp1", step_pulse, 1'b1);
      tick_n(1);
      chk("resume_led", led, 3'b101);

      // Mid-run reset in breathe, then MODE 0->3->0
      do_reset(2'd2, 2);
      rst_n = 1'b1;
      tick_n(30);
      rst_n = 1'b0;
      mode  = 2'd0;
      tick_n(1);
      chk("midrst_led", led, 3'b111);
      chk("midrst_sp", step_pulse, 1'b0);
      rst_n = 1'b1;
      tick_n(1);
      chk("midrst_pat", led, 3'b110);
      tick_n(4);
      chk("rot2_led", led, 3'b101);
      mode = 2'd3;
      tick_n(1);
      chk("off_led", led, 3'b111);
      tick_n(2);
      chk("off_led_hold", led, 3'b111);
      chk("off_sp", step_pulse, 1'b0);
      mode = 2'd0;
      for (int c = 1; c <= 5; c++) begin
         tick_n(1);
         chk("back_led", led, 3'b101);
         chk("back_sp", step_pulse, c == 5);
      end
      tick_n(1);
      chk("back_next", led, 3'b011);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
